register_allocator_multi: RTL and testbench

//  Physical-register free-list allocator for the rename stage. Grants up to AllocWidth tags per cycle,

---
 rtl/register_allocator_multi.sv | 164 ++++++++++++++++
 tb/tb_register_allocator_multi.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_allocator_multi.sv
// Rename-stage physical register free list with branch checkpoints.
// Tracks per-checkpoint allocation sets so a mispredict frees exactly what followed it.
module register_allocator_multi #(
    parameter int PhyRegIDWidth           = 5,
    parameter int NumRegsAllocatedOnReset = 16,
    parameter int AllocWidth              = 2,
    parameter int CommitWidth             = 2,
    parameter int BridWidth               = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 flush_i,
    input  logic                                 mispredict_i,
    input  logic [BridWidth-1:0]                 mispredict_brid_i,
    input  logic                                 resolve_i,
    input  logic [BridWidth-1:0]                 resolve_brid_i,
    input  logic [CommitWidth-1:0]               commit_i,
    input  logic [CommitWidth*PhyRegIDWidth-1:0] commit_tag_i,
    input  logic [CommitWidth*PhyRegIDWidth-1:0] commit_old_tag_i,
    input  logic [$clog2(AllocWidth+1)-1:0]      alloc_num_i,
    input  logic                                 alloc_checkpoint_i,
    output logic                                 alloc_ready_o,
    output logic [AllocWidth*PhyRegIDWidth-1:0]  alloc_tag_o,
    output logic                                 ckpt_avail_o,
    output logic [BridWidth-1:0]                 ckpt_brid_o,
    output logic [$clog2(2**PhyRegIDWidth+1)-1:0] free_count_o
);
    localparam int NumRegs = 2 ** PhyRegIDWidth;
    localparam int NumCkpt = 2 ** BridWidth;
    localparam int CntW    = $clog2(NumRegs + 1);
    localparam int NumW    = $clog2(AllocWidth + 1);
    localparam int W       = PhyRegIDWidth;

    logic [NumRegs-1:0]              allocated_q, allocated_d;
    logic [NumRegs-1:0]              speculative_q, speculative_d;
    logic [NumCkpt-1:0]              live_q, live_d;
    logic [NumCkpt-1:0][NumRegs-1:0] set_q, set_d;
    logic [NumCkpt-1:0][NumCkpt-1:0] dep_q, dep_d;

    logic [AllocWidth-1:0][W-1:0]    lane_tag;
    logic [NumRegs-1:0]              pick_mask;
    logic [NumCkpt-1:0]              kill;
    logic                            fire;
    logic [W-1:0]                    ctag, otag;

    // Each lane takes the lowest reg not already taken by a lower lane.
    always_comb begin
        pick_mask = allocated_q;
        lane_tag  = '0;
        for (int k = 0; k < AllocWidth; k++) begin
            for (int i = NumRegs - 1; i >= 0; i--) begin
                if (!pick_mask[i]) lane_tag[k] = W'(i);
            end
            pick_mask[lane_tag[k]] = 1'b1;
        end
    end

    assign alloc_tag_o = lane_tag;

    always_comb begin
        free_count_o = '0;
        for (int i = 0; i < NumRegs; i++) begin
            free_count_o = free_count_o + {{(CntW-1){1'b0}}, ~allocated_q[i]};
        end
    end

    always_comb begin
        ckpt_brid_o = '0;
        for (int c = NumCkpt - 1; c >= 0; c--) begin
            if (!live_q[c]) ckpt_brid_o = BridWidth'(c);
        end
    end

    assign ckpt_avail_o  = ~&live_q;
    assign alloc_ready_o = (free_count_o >= CntW'(AllocWidth)) & ~flush_i & ~mispredict_i
                         & (~alloc_checkpoint_i | ckpt_avail_o);
    assign fire = alloc_ready_o & ((alloc_num_i != '0) | alloc_checkpoint_i);

    always_comb begin
        allocated_d   = allocated_q;
        speculative_d = speculative_q;
        live_d        = live_q;
        set_d         = set_q;
        dep_d         = dep_q;
        kill          = '0;
        ctag          = '0;
        otag          = '0;
        if (flush_i) begin
            allocated_d   = allocated_q & ~speculative_q;
            speculative_d = '0;
            live_d        = '0;
        end else begin
            if (mispredict_i && live_q[mispredict_brid_i]) begin
                kill[mispredict_brid_i] = 1'b1;
                for (int c = 0; c < NumCkpt; c++) begin
                    if (live_q[c] && dep_q[c][mispredict_brid_i]) kill[c] = 1'b1;
                end
                allocated_d   = allocated_d & ~set_q[mispredict_brid_i];
                speculative_d = speculative_d & ~set_q[mispredict_brid_i];
                live_d        = live_d & ~kill;
            end
            if (resolve_i && live_q[resolve_brid_i]
                && !(mispredict_i && mispredict_brid_i == resolve_brid_i)) begin
                live_d[resolve_brid_i] = 1'b0;
                for (int c = 0; c < NumCkpt; c++) dep_d[c][resolve_brid_i] = 1'b0;
            end
            if (fire) begin
                for (int k = 0; k < AllocWidth; k++) begin
                    if (NumW'(k) < alloc_num_i) begin
                        allocated_d[lane_tag[k]]   = 1'b1;
                        speculative_d[lane_tag[k]] = 1'b1;
                        for (int c = 0; c < NumCkpt; c++) begin
                            if (live_q[c]) set_d[c][lane_tag[k]] = 1'b1;
                        end
                    end
                end
                // Same-cycle lanes precede the branch, so its set starts empty.
                if (alloc_checkpoint_i) begin
                    dep_d[ckpt_brid_o]  = live_d;
                    set_d[ckpt_brid_o]  = '0;
                    live_d[ckpt_brid_o] = 1'b1;
                end
            end
        end
        for (int k = 0; k < CommitWidth; k++) begin
            if (commit_i[k]) begin
                ctag = commit_tag_i[k*W +: W];
                otag = commit_old_tag_i[k*W +: W];
                if (flush_i) allocated_d[ctag] = 1'b1;
                speculative_d[ctag] = 1'b0;
                allocated_d[otag]   = 1'b0;
                speculative_d[otag] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumRegs; i++) begin
                allocated_q[i] <= (i < NumRegsAllocatedOnReset);
            end
            speculative_q <= '0;
            live_q        <= '0;
            set_q         <= '0;
            dep_q         <= '0;
        end else begin
            allocated_q   <= allocated_d;
            speculative_q <= speculative_d;
            live_q        <= live_d;
            set_q         <= set_d;
            dep_q         <= dep_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && !flush_i && mispredict_i && live_q[mispredict_brid_i]) begin
            for (int k = 0; k < CommitWidth; k++) begin
                if (commit_i[k]) begin
                    assert (!set_q[mispredict_brid_i][commit_tag_i[k*W +: W]]);
                end
            end
        end
    end
endmodule

// File: tb/tb_register_allocator_multi.sv
// Directed scenarios plus randomized traffic checked against a list-based model.
module tb_register_allocator_multi;
    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       flush_i = 1'b0;
    logic       mispredict_i = 1'b0;
    logic [1:0] mispredict_brid_i = '0;
    logic       resolve_i = 1'b0;
    logic [1:0] resolve_brid_i = '0;
    logic [1:0] commit_i = '0;
    logic [9:0] commit_tag_i = '0;
    logic [9:0] commit_old_tag_i = '0;
    logic [1:0] alloc_num_i = '0;
    logic       alloc_checkpoint_i = 1'b0;
    logic       alloc_ready_o;
    logic [9:0] alloc_tag_o;
    logic       ckpt_avail_o;
    logic [1:0] ckpt_brid_o;
    logic [5:0] free_count_o;

    int errors = 0;
    int checks = 0;

    bit m_alloc [32];
    bit m_spec  [32];
    bit m_live  [4];
    int m_seq   [4];
    int m_regs  [4][$];
    int seq_ctr = 0;

    register_allocator_multi dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .mispredict_i(mispredict_i), .mispredict_brid_i(mispredict_brid_i),
        .resolve_i(resolve_i), .resolve_brid_i(resolve_brid_i),
        .commit_i(commit_i), .commit_tag_i(commit_tag_i),
        .commit_old_tag_i(commit_old_tag_i), .alloc_num_i(alloc_num_i),
        .alloc_checkpoint_i(alloc_checkpoint_i), .alloc_ready_o(alloc_ready_o),
        .alloc_tag_o(alloc_tag_o), .ckpt_avail_o(ckpt_avail_o),
        .ckpt_brid_o(ckpt_brid_o), .free_count_o(free_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int m_free_cnt();
        int n = 0;
        for (int i = 0; i < 32; i++) if (!m_alloc[i]) n++;
        return n;
    endfunction

    function automatic int m_lane(input int k);
        int seen = 0;
        for (int i = 0; i < 32; i++) begin
            if (!m_alloc[i]) begin
                if (seen == k) return i;
                seen++;
            end
        end
        return 0;
    endfunction

    function automatic bit m_avail();
        for (int c = 0; c < 4; c++) if (!m_live[c]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_brid();
        for (int c = 0; c < 4; c++) if (!m_live[c]) return c;
        return 0;
    endfunction

    function automatic bit m_ready();
        return m_free_cnt() >= 2 && !flush_i && !mispredict_i
            && (!alloc_checkpoint_i || m_avail());
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin
            m_alloc[i] = (i < 16);
            m_spec[i]  = 1'b0;
        end
        for (int c = 0; c < 4; c++) begin
            m_live[c] = 1'b0;
            m_regs[c].delete();
        end
    endtask

    task automatic m_step();
        int lane [2];
        int brid, mb, rb, r;
        bit fire;
        lane[0] = m_lane(0);
        lane[1] = m_lane(1);
        brid = m_brid();
        fire = m_ready() && (alloc_num_i != 0 || alloc_checkpoint_i);
        mb = int'(mispredict_brid_i);
        rb = int'(resolve_brid_i);
        if (flush_i) begin
            for (int i = 0; i < 32; i++) begin
                if (m_spec[i]) begin
                    m_alloc[i] = 1'b0;
                    m_spec[i]  = 1'b0;
                end
            end
            for (int c = 0; c < 4; c++) begin
                m_live[c] = 1'b0;
                m_regs[c].delete();
            end
        end else begin
            if (mispredict_i && m_live[mb]) begin
                foreach (m_regs[mb][j]) begin
                    m_alloc[m_regs[mb][j]] = 1'b0;
                    m_spec[m_regs[mb][j]]  = 1'b0;
                end
                for (int c = 0; c < 4; c++) begin
                    if (c != mb && m_live[c] && m_seq[c] > m_seq[mb]) m_live[c] = 1'b0;
                end
                m_live[mb] = 1'b0;
            end
            if (resolve_i && m_live[rb] && !(mispredict_i && mb == rb)) m_live[rb] = 1'b0;
            if (fire) begin
                for (int k = 0; k < 2; k++) begin
                    if (k < int'(alloc_num_i)) begin
                        r = lane[k];
                        m_alloc[r] = 1'b1;
                        m_spec[r]  = 1'b1;
                        for (int c = 0; c < 4; c++) if (m_live[c]) m_regs[c].push_back(r);
                    end
                end
                if (alloc_checkpoint_i) begin
                    seq_ctr++;
                    m_live[brid] = 1'b1;
                    m_seq[brid]  = seq_ctr;
                    m_regs[brid].delete();
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (commit_i[k]) begin
                r = int'(commit_tag_i[k*5 +: 5]);
                if (flush_i) m_alloc[r] = 1'b1;
                m_spec[r] = 1'b0;
                r = int'(commit_old_tag_i[k*5 +: 5]);
                m_alloc[r] = 1'b0;
                m_spec[r]  = 1'b0;
            end
        end
    endtask

    task automatic check_outputs();
        check("free_count", int'(free_count_o), m_free_cnt());
        check("tag0", int'(alloc_tag_o[4:0]), m_lane(0));
        check("tag1", int'(alloc_tag_o[9:5]), m_lane(1));
        check("ckpt_avail", int'(ckpt_avail_o), int'(m_avail()));
        check("ckpt_brid", int'(ckpt_brid_o), m_brid());
        check("ready", int'(alloc_ready_o), int'(m_ready()));
    endtask

    task automatic idle();
        flush_i = 1'b0;
        mispredict_i = 1'b0;
        mispredict_brid_i = '0;
        resolve_i = 1'b0;
        resolve_brid_i = '0;
        commit_i = '0;
        commit_tag_i = '0;
        commit_old_tag_i = '0;
        alloc_num_i = '0;
        alloc_checkpoint_i = 1'b0;
    endtask

    task automatic cycle();
        #1;
        check_outputs();
        m_step();
        @(posedge clk_i);
        #1;
        idle();
    endtask

    task automatic do_reset();
        idle();
        rst_ni = 1'b0;
        m_reset();
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        int c;
        do_reset();
        #1;
        check("rst_free", int'(free_count_o), 16);
        check("rst_tags", int'(alloc_tag_o), (17 << 5) | 16);
        check("rst_avail", int'(ckpt_avail_o), 1);
        check("rst_brid", int'(ckpt_brid_o), 0);

        for (int i = 0; i < 8; i++) begin
            alloc_num_i = 2'd2;
            #1;
            check("t1_tag0", int'(alloc_tag_o[4:0]), 16 + 2 * i);
            check("t1_tag1", int'(alloc_tag_o[9:5]), 17 + 2 * i);
            cycle();
        end
        #1;
        check("t1_full_free", int'(free_count_o), 0);
        check("t1_full_ready", int'(alloc_ready_o), 0);

        commit_i = 2'b01;
        commit_tag_i = 10'd4;
        commit_old_tag_i = 10'd20;
        cycle();
        #1;
        check("t2_free1", int'(free_count_o), 1);
        check("t2_ready0", int'(alloc_ready_o), 0);
        commit_i = 2'b01;
        commit_tag_i = 10'd5;
        commit_old_tag_i = 10'd21;
        cycle();
        #1;
        check("t2_ready1", int'(alloc_ready_o), 1);
        check("t2_tags", int'(alloc_tag_o), (21 << 5) | 20);

        do_reset();
        alloc_num_i = 2'd2;
        alloc_checkpoint_i = 1'b1;
        cycle();
        alloc_num_i = 2'd2;
        cycle();
        alloc_num_i = 2'd1;
        alloc_checkpoint_i = 1'b1;
        #1;
        check("t3_brid1", int'(ckpt_brid_o), 1);
        cycle();
        mispredict_i = 1'b1;
        mispredict_brid_i = 2'd0;
        cycle();
        #1;
        check("t3_free", int'(free_count_o), 14);
        check("t3_tag0", int'(alloc_tag_o[4:0]), 18);
        check("t3_brid0", int'(ckpt_brid_o), 0);
        cycle();

        do_reset();
        for (int i = 0; i < 4; i++) begin
            alloc_checkpoint_i = 1'b1;
            cycle();
        end
        alloc_checkpoint_i = 1'b1;
        #1;
        check("t4_avail", int'(ckpt_avail_o), 0);
        check("t4_blocked", int'(alloc_ready_o), 0);
        idle();
        resolve_i = 1'b1;
        resolve_brid_i = 2'd2;
        cycle();
        #1;
        check("t4_brid2", int'(ckpt_brid_o), 2);
        cycle();

        do_reset();
        alloc_num_i = 2'd2;
        alloc_checkpoint_i = 1'b1;
        cycle();
        alloc_num_i = 2'd2;
        cycle();
        flush_i = 1'b1;
        commit_i = 2'b01;
        commit_tag_i = 10'd16;
        commit_old_tag_i = 10'd3;
        cycle();
        #1;
        check("t5_free", int'(free_count_o), 16);
        check("t5_tag0", int'(alloc_tag_o[4:0]), 3);
        check("t5_tag1", int'(alloc_tag_o[9:5]), 17);
        check("t5_avail", int'(ckpt_avail_o), 1);
        cycle();

        for (int i = 0; i < 3; i++) begin
            alloc_num_i = 2'd2;
            cycle();
        end
        alloc_num_i = 2'd2;
        #2;
        rst_ni = 1'b0;
        #1;
        check("t6_free", int'(free_count_o), 16);
        check("t6_tags", int'(alloc_tag_o), (17 << 5) | 16);
        check("t6_avail", int'(ckpt_avail_o), 1);
        check("t6_brid", int'(ckpt_brid_o), 0);
        m_reset();
        idle();
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        for (int n = 0; n < 600; n++) begin
            alloc_num_i = 2'($urandom_range(0, 2));
            alloc_checkpoint_i = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) < 10) begin
                c = int'($urandom_range(0, 3));
                for (int j = 0; j < 4; j++) begin
                    if (!mispredict_i && m_live[(c + j) % 4]) begin
                        mispredict_i = 1'b1;
                        mispredict_brid_i = 2'((c + j) % 4);
                    end
                end
            end
            if ($urandom_range(0, 99) < 15) begin
                resolve_i = 1'b1;
                resolve_brid_i = 2'($urandom_range(0, 3));
            end
            if (!mispredict_i) begin
                commit_i = 2'($urandom_range(0, 3));
                commit_tag_i = 10'($urandom);
                commit_old_tag_i = 10'($urandom);
            end
            flush_i = ($urandom_range(0, 99) < 3);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
